// File: rtl/bus_reg_bank_if.sv
// Bus interface for bus_reg_bank.
// Groups the command port (bus_in, op_valid, op, sel), the read-back port
// (rd_en, rd_sel, bus_out, rd_valid) and the status outputs
// (out_all, dirty, wrap, err).
//   master : the bus/sequencer side, which drives commands and read requests
//   slave  : the register bank, which drives read-back data and status
interface bus_reg_bank_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   localparam int SEL_W = $clog2(DEPTH);

   logic [WIDTH-1:0]       bus_in;
   logic                   op_valid;
   logic [2:0]             op;
   logic [SEL_W-1:0]       sel;
   logic                   rd_en;
   logic [SEL_W-1:0]       rd_sel;
   logic [WIDTH-1:0]       bus_out;
   logic                   rd_valid;
   logic [DEPTH*WIDTH-1:0] out_all;
   logic [DEPTH-1:0]       dirty;
   logic                   wrap;
   logic                   err;

   modport master (
      output bus_in, op_valid, op, sel, rd_en, rd_sel,
      input  bus_out, rd_valid, out_all, dirty, wrap, err
   );

   modport slave (
      input  bus_in, op_valid, op, sel, rd_en, rd_sel,
      output bus_out, rd_valid, out_all, dirty, wrap, err
   );
endinterface

// File: rtl/bus_reg_bank.sv
// bus_reg_bank: addressable bank of DEPTH registers, WIDTH bits each.
// Each register has a staging hold word loaded from the bus and a visible
// out word updated by COMMIT / LOAD_COMMIT / INC / DEC / CLEAR. A registered
// read-back port returns out[rd_sel]. All outputs are registered.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : bus_reg_bank_if.slave (commands, read-back, out_all, dirty,
//          wrap and err pulses)
module bus_reg_bank #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input logic           clk,
   input logic           rst,
   bus_reg_bank_if.slave bus
);
   localparam int               SEL_W   = $clog2(DEPTH);
   localparam logic [SEL_W:0]   DEPTH_V = (SEL_W + 1)'(DEPTH);
   localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH - 1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      OP_NOP         = 3'b000,
      OP_LOAD        = 3'b001,
      OP_COMMIT      = 3'b010,
      OP_LOAD_COMMIT = 3'b011,
      OP_INC         = 3'b100,
      OP_DEC         = 3'b101,
      OP_CLEAR       = 3'b110,
      OP_RSVD        = 3'b111
   } op_e;

   op_e                          op_s;
   logic                         sel_ok_s;
   logic [DEPTH-1:0][WIDTH-1:0]  hold_r;
   logic [DEPTH-1:0][WIDTH-1:0]  hold_nxt_s;
   logic [DEPTH-1:0][WIDTH-1:0]  out_r;
   logic [DEPTH-1:0][WIDTH-1:0]  out_nxt_s;
   logic [DEPTH-1:0]             dirty_r;
   logic [DEPTH-1:0]             dirty_nxt_s;
   logic                         wrap_r;
   logic                         wrap_nxt_s;
   logic                         err_r;
   logic                         err_nxt_s;
   logic [WIDTH-1:0]             rd_data_s;
   logic [WIDTH-1:0]             bus_out_r;
   logic [WIDTH-1:0]             bus_out_nxt_s;
   logic                         rd_valid_r;

   assign op_s = op_e'(bus.op);
   // Only reachable false for non-power-of-2 DEPTH.
   assign sel_ok_s = ({1'b0, bus.sel} < DEPTH_V);

   // Command decode: next hold/out/dirty state plus wrap and err pulses.
   always_comb begin
      hold_nxt_s  = hold_r;
      out_nxt_s   = out_r;
      dirty_nxt_s = dirty_r;
      wrap_nxt_s  = 1'b0;
      err_nxt_s   = 1'b0;
      if (bus.op_valid && (op_s != OP_NOP)) begin
         if ((op_s == OP_RSVD) || !sel_ok_s) begin
            err_nxt_s = 1'b1;
         end else begin
            // Compare against each index rather than indexing by sel so an
            // out-of-range select can never address a missing register.
            for (int i = 0; i < DEPTH; i++) begin
               if (bus.sel == SEL_W'(i)) begin
                  case (op_s)
                     OP_LOAD: begin
                        hold_nxt_s[i]  = bus.bus_in;
                        dirty_nxt_s[i] = 1'b1;
                     end
                     OP_COMMIT: begin
                        out_nxt_s[i]   = hold_r[i];
                        dirty_nxt_s[i] = 1'b0;
                     end
                     OP_LOAD_COMMIT: begin
                        hold_nxt_s[i]  = bus.bus_in;
                        out_nxt_s[i]   = bus.bus_in;
                        dirty_nxt_s[i] = 1'b0;
                     end
                     OP_INC: begin
                        out_nxt_s[i] = out_r[i] + ONE;
                        wrap_nxt_s   = &out_r[i];
                     end
                     OP_DEC: begin
                        out_nxt_s[i] = out_r[i] - ONE;
                        wrap_nxt_s   = (out_r[i] == ZERO);
                     end
                     OP_CLEAR: begin
                        hold_nxt_s[i]  = ZERO;
                        out_nxt_s[i]   = ZERO;
                        dirty_nxt_s[i] = 1'b0;
                     end
                     default: begin
                        hold_nxt_s[i] = hold_r[i];
                     end
                  endcase
               end else begin
                  hold_nxt_s[i] = hold_r[i];
               end
            end
         end
      end else begin
         err_nxt_s = 1'b0;
      end
   end

   // Read-back mux: an out-of-range rd_sel matches nothing and reads zero.
   always_comb begin
      rd_data_s = ZERO;
      for (int i = 0; i < DEPTH; i++) begin
         rd_data_s = rd_data_s | ((bus.rd_sel == SEL_W'(i)) ? out_r[i] : ZERO);
      end
      bus_out_nxt_s = bus.rd_en ? rd_data_s : bus_out_r;
   end

   // State and output registers; read-back samples pre-update out_r.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_r     <= '0;
         out_r      <= '0;
         dirty_r    <= {DEPTH{1'b0}};
         wrap_r     <= 1'b0;
         err_r      <= 1'b0;
         bus_out_r  <= ZERO;
         rd_valid_r <= 1'b0;
      end else begin
         hold_r     <= hold_nxt_s;
         out_r      <= out_nxt_s;
         dirty_r    <= dirty_nxt_s;
         wrap_r     <= wrap_nxt_s;
         err_r      <= err_nxt_s;
         bus_out_r  <= bus_out_nxt_s;
         rd_valid_r <= bus.rd_en;
      end
   end

   assign bus.out_all  = out_r;
   assign bus.dirty    = dirty_r;
   assign bus.wrap     = wrap_r;
   assign bus.err      = err_r;
   assign bus.bus_out  = bus_out_r;
   assign bus.rd_valid = rd_valid_r;
endmodule

// File: tb/tb_bus_reg_bank.sv
// Directed testbench for bus_reg_bank: a DEPTH=4 bank for the main command
// and read-back behaviour, and a DEPTH=3 bank for out-of-range selects.
module tb_bus_reg_bank;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   bus_reg_bank_if #(.WIDTH(8), .DEPTH(4)) bi4 ();
   bus_reg_bank_if #(.WIDTH(8), .DEPTH(3)) bi3 ();

   bus_reg_bank #(.WIDTH(8), .DEPTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bi4.slave));
   bus_reg_bank #(.WIDTH(8), .DEPTH(3)) dut3 (.clk(clk), .rst(rst), .bus(bi3.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge and settle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cmd4(input logic [2:0] o, input logic [1:0] s, input logic [7:0] d);
      bi4.op_valid = 1'b1;
      bi4.op       = o;
      bi4.sel      = s;
      bi4.bus_in   = d;
   endtask

   task automatic cmd3(input logic [2:0] o, input logic [1:0] s, input logic [7:0] d);
      bi3.op_valid = 1'b1;
      bi3.op       = o;
      bi3.sel      = s;
      bi3.bus_in   = d;
   endtask

   task automatic idle();
      bi4.op_valid = 1'b0; bi4.op = 3'b000; bi4.sel = 2'd0; bi4.bus_in = 8'h00;
      bi4.rd_en    = 1'b0; bi4.rd_sel = 2'd0;
      bi3.op_valid = 1'b0; bi3.op = 3'b000; bi3.sel = 2'd0; bi3.bus_in = 8'h00;
      bi3.rd_en    = 1'b0; bi3.rd_sel = 2'd0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      idle();
      #11;
      check("rst_out_all", 64'(bi4.out_all), 64'h0);
      check("rst_dirty", 64'(bi4.dirty), 64'h0);
      check("rst_rd_valid", 64'(bi4.rd_valid), 64'h0);
      rst = 1'b0;

      // Read back every register after reset.
      for (int r = 0; r < 4; r++) begin
         bi4.rd_en  = 1'b1;
         bi4.rd_sel = 2'(r);
         step();
         check($sformatf("rst_rd_data_r%0d", r), 64'(bi4.bus_out), 64'h0);
         check($sformatf("rst_rd_valid_r%0d", r), 64'(bi4.rd_valid), 64'h1);
      end
      idle();
      step();
      check("rd_valid_drop", 64'(bi4.rd_valid), 64'h0);
      check("rst_dirty_after", 64'(bi4.dirty), 64'h0);

      // LOAD then COMMIT r1.
      cmd4(3'b001, 2'd1, 8'hA5);
      step();
      check("load_r1_dirty", 64'(bi4.dirty), 64'h2);
      check("load_r1_out", 64'(bi4.out_all), 64'h0);
      cmd4(3'b010, 2'd1, 8'h00);
      step();
      check("commit_r1_out", 64'(bi4.out_all), 64'h0000A500);
      check("commit_r1_dirty", 64'(bi4.dirty), 64'h0);

      // LOAD_COMMIT r2 = FF, then wrap on INC and DEC.
      cmd4(3'b011, 2'd2, 8'hFF);
      step();
      check("lc_r2_out", 64'(bi4.out_all), 64'h00FFA500);
      check("lc_r2_wrap", 64'(bi4.wrap), 64'h0);
      cmd4(3'b100, 2'd2, 8'h00);
      step();
      check("inc_r2_out", 64'(bi4.out_all), 64'h0000A500);
      check("inc_r2_wrap", 64'(bi4.wrap), 64'h1);
      idle();
      step();
      check("wrap_one_cycle", 64'(bi4.wrap), 64'h0);
      cmd4(3'b101, 2'd2, 8'h00);
      step();
      check("dec_r2_out", 64'(bi4.out_all), 64'h00FFA500);
      check("dec_r2_wrap", 64'(bi4.wrap), 64'h1);
      cmd4(3'b100, 2'd2, 8'h00);
      step();
      check("inc2_r2_out", 64'(bi4.out_all), 64'h0000A500);
      cmd4(3'b010, 2'd2, 8'h00);
      step();
      check("commit_r2_hold", 64'(bi4.out_all), 64'h00FFA500);
      check("commit_r2_wrap", 64'(bi4.wrap), 64'h0);

      // Back-to-back LOAD / COMMIT on r0.
      cmd4(3'b001, 2'd0, 8'h10);
      step();
      check("b2b_load_out", 64'(bi4.out_all), 64'h00FFA500);
      check("b2b_load_dirty", 64'(bi4.dirty), 64'h1);
      cmd4(3'b010, 2'd0, 8'h00);
      step();
      check("b2b_commit_out", 64'(bi4.out_all), 64'h00FFA510);

      // INC r0 with a same-cycle read of r0 returns old data.
      cmd4(3'b100, 2'd0, 8'h00);
      bi4.rd_en  = 1'b1;
      bi4.rd_sel = 2'd0;
      step();
      check("coll_rd_old", 64'(bi4.bus_out), 64'h10);
      check("coll_out", 64'(bi4.out_all), 64'h00FFA511);
      bi4.op_valid = 1'b0;
      step();
      check("coll_rd_new", 64'(bi4.bus_out), 64'h11);
      idle();
      step();
      check("rd_hold_data", 64'(bi4.bus_out), 64'h11);
      check("rd_hold_valid", 64'(bi4.rd_valid), 64'h0);

      // CLEAR wipes hold, out and dirty; DEC from zero wraps.
      cmd4(3'b001, 2'd1, 8'h3C);
      step();
      cmd4(3'b110, 2'd1, 8'h00);
      step();
      check("clear_out", 64'(bi4.out_all), 64'h00FF0011);
      check("clear_dirty", 64'(bi4.dirty), 64'h0);
      cmd4(3'b010, 2'd1, 8'h00);
      step();
      check("clear_hold", 64'(bi4.out_all), 64'h00FF0011);
      cmd4(3'b101, 2'd1, 8'h00);
      step();
      check("dec0_out", 64'(bi4.out_all), 64'h00FFFF11);
      check("dec0_wrap", 64'(bi4.wrap), 64'h1);
      idle();

      // DEPTH=3 bank: reserved op, out-of-range sel and rd_sel.
      cmd3(3'b011, 2'd0, 8'h33);
      step();
      check("d3_lc_out", 64'(bi3.out_all), 64'h000033);
      cmd3(3'b111, 2'd0, 8'h44);
      step();
      check("d3_rsvd_err", 64'(bi3.err), 64'h1);
      check("d3_rsvd_out", 64'(bi3.out_all), 64'h000033);
      check("d3_rsvd_dirty", 64'(bi3.dirty), 64'h0);
      idle();
      step();
      check("d3_err_one_cycle", 64'(bi3.err), 64'h0);
      cmd3(3'b001, 2'd3, 8'h77);
      step();
      check("d3_badsel_err", 64'(bi3.err), 64'h1);
      check("d3_badsel_out", 64'(bi3.out_all), 64'h000033);
      check("d3_badsel_dirty", 64'(bi3.dirty), 64'h0);
      cmd3(3'b000, 2'd3, 8'h00);
      step();
      check("d3_nop_badsel_err", 64'(bi3.err), 64'h0);
      idle();
      bi3.op = 3'b111;
      step();
      check("d3_novalid_err", 64'(bi3.err), 64'h0);
      idle();
      bi3.rd_en  = 1'b1;
      bi3.rd_sel = 2'd0;
      step();
      check("d3_rd_r0", 64'(bi3.bus_out), 64'h33);
      bi3.rd_sel = 2'd3;
      step();
      check("d3_rd_bad_data", 64'(bi3.bus_out), 64'h0);
      check("d3_rd_bad_valid", 64'(bi3.rd_valid), 64'h1);
      check("d3_rd_bad_err", 64'(bi3.err), 64'h0);
      idle();

      // Asynchronous reset between LOAD and COMMIT.
      cmd4(3'b001, 2'd3, 8'h5A);
      step();
      check("pre_rst_dirty", 64'(bi4.dirty), 64'h8);
      idle();
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_dirty", 64'(bi4.dirty), 64'h0);
      check("async_rst_out", 64'(bi4.out_all), 64'h0);
      check("async_rst_bus_out", 64'(bi4.bus_out), 64'h0);
      #3;
      rst = 1'b0;
      cmd4(3'b010, 2'd3, 8'h00);
      step();
      check("post_rst_commit", 64'(bi4.out_all), 64'h0);
      check("post_rst_dirty", 64'(bi4.dirty), 64'h0);
      idle();
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/bus_reg_bank.md
# bus_reg_bank

Parametrised bank of `DEPTH` bus-attached registers, each `WIDTH` bits wide. Every register has a two-stage structure: a staging `hold` word captured from the bus, and a visible `out` word updated on command. The bank adds single-cycle increment, decrement and clear on the visible word, a registered bus read-back port, per-register dirty flags, and wrap/error reporting. It sits between the CPU data bus and the control sequencer, and replaces individual A/B/temp registers with one addressable block.

## Interface
- `WIDTH`, default 8: data width of each register; minimum 2.
- `DEPTH`, default 4: number of registers; minimum 2.
- `SEL_W`, localparam = `$clog2(DEPTH)`: width of the select fields.
- `clk`, in, 1: clock, rising-edge.
- `rst`, in, 1: reset; asynchronous, active-high.
- `bus_in`, in, `WIDTH`: data from the bus.
- `op_valid`, in, 1: `op` and `sel` are valid this cycle.
- `op`, in, 3: command code, defined under Operation.
- `sel`, in, `SEL_W`: target register for `op`.
- `rd_en`, in, 1: read-back request.
- `rd_sel`, in, `SEL_W`: register to read back.
- `bus_out`, out, `WIDTH`: registered read-back data.
- `rd_valid`, out, 1: `bus_out` is valid this cycle.
- `out_all`, out, `DEPTH*WIDTH`: all visible words; register i occupies bits `[i*WIDTH +: WIDTH]`.
- `dirty`, out, `DEPTH`: `hold[i]` has been loaded since the last commit or clear of register i.
- `wrap`, out, 1: one-cycle pulse on an INC or DEC that wraps.
- `err`, out, 1: one-cycle pulse on an illegal command.

## Operation
- Commands apply only when `op_valid`=1 and are executed at the rising edge.
  - 000 NOP.
  - 001 LOAD: `hold[sel]`<=`bus_in`; `dirty[sel]`<=1.
  - 010 COMMIT: `out[sel]`<=`hold[sel]`; `dirty[sel]`<=0.
  - 011 LOAD_COMMIT: `hold[sel]` and `out[sel]` both <=`bus_in`; `dirty[sel]`<=0.
  - 100 INC: `out[sel]`<=`out[sel]`+1, modulo 2^WIDTH.
  - 101 DEC: `out[sel]`<=`out[sel]`-1, modulo 2^WIDTH.
  - 110 CLEAR: `hold[sel]`, `out[sel]` and `dirty[sel]` all <=0.
  - 111 reserved: no state change; `err` pulses.
- INC and DEC leave `hold` and `dirty` unchanged.
- `wrap` pulses on INC when `out[sel]` is all-ones, and on DEC when `out[sel]` is 0.
- A `sel` value >= `DEPTH` (non-power-of-2 `DEPTH` only) gives no state change and an `err` pulse, for every op except NOP.
- When `op_valid`=0, there are no state changes and no pulses.
- Read-back: when `rd_en`=1, `bus_out`<=`out[rd_sel]` and `rd_valid`<=1. When `rd_en`=0, `rd_valid`<=0 and `bus_out` holds its last value.
- A `rd_sel` value >= `DEPTH` gives `bus_out`<=0 and `rd_valid`<=1, with no `err`.
- Read/op collision on the same register in the same cycle: read-back returns the pre-update `out` value (old data).
- Reset: all `hold`, `out`, `dirty`, `bus_out`, `rd_valid`, `wrap` and `err` go to 0 immediately. This includes reset asserted mid-sequence; no pending state survives.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- `out_all` and `dirty` reflect a command the cycle after its edge (latency 1).
- `bus_out`/`rd_valid` have latency 1 from `rd_en`.
- `wrap` and `err` are high for exactly the cycle following the offending edge.
- Back-to-back commands to the same register every cycle are legal, with each operating on the result of the previous one. Example: LOAD then COMMIT on consecutive cycles makes `out` equal the loaded value 2 cycles after LOAD.
- `op` and `rd` operate independently every cycle; there is no backpressure.

## Test plan
- Reset, then `rd_en` on each register -> every `bus_out`=0, `rd_valid`=1 one cycle later, and `dirty`=0.
- LOAD r1 with 0xA5 -> `dirty[1]`=1 while `out_all` r1 stays 0x00. COMMIT r1 -> `out` r1=0xA5 and `dirty[1]`=0.
- LOAD_COMMIT r2 with 0xFF, then INC r2 -> `out` r2=0x00 and `wrap` pulses once. DEC r2 -> 0xFF and `wrap` pulses again. `hold` r2 is still 0xFF, confirmed by COMMIT returning 0xFF.
- Same cycle: INC r0 (`out`=0x10) with `rd_en`,`rd_sel`=0 -> `bus_out`=0x10, and the next read gives 0x11.
- op=111 and, with `DEPTH`=3, `sel`=3 -> `err` pulses once each with no change to `out_all` or `dirty`. With `rd_sel`=3 -> `bus_out`=0 and no `err`.
- LOAD r3 with 0x5A, then assert `rst` asynchronously before COMMIT -> `dirty`=0. After release, COMMIT r3 gives `out`=0x00.
